// File: rtl/tap_ctrl_pkg.sv
// tap_ctrl_pkg: shared types for the IEEE 1149.1 TAP controller.
// Holds the fixed 4-bit state encodings and the packed output-control vector.
// Optional build macro used by the top: TAPC_STATE_OUT_EN.
package tap_ctrl_pkg;

   // State encodings are fixed so that state_o can be read by external tools.
   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SH_DR    = 4'h2,
      EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3,
      EX2_DR   = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SH_IR    = 4'hA,
      EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB,
      EX2_IR   = 4'h8,
      UPD_IR   = 4'hD
   } tapc_state_t;

   // All chain controls driven by the controller, in one registered vector.
   typedef struct packed {
      logic reset;
      logic select;
      logic ir_shift;
      logic ir_clock;
      logic ir_upd;
      logic dr_shift;
      logic dr_clock;
      logic dr_upd;
      logic tdo_en;
   } tapc_out_t;

   // Output vector seen while held in reset: only the test-logic reset is high.
   localparam tapc_out_t TAPC_OUT_RESET = '{reset: 1'b1, default: 1'b0};

endpackage

// File: rtl/tap_ctrl_if.sv
// tap_ctrl_if: TMS input and chain-control outputs of the TAP controller.
// The controller connects through the slave modport; the driver of TMS
// (debug port front end or a bench) uses the master modport.
// Handshake: none; tms_i is sampled on every rising tck_i, and every output is a
// registered level that is valid for the whole cycle the controller holds a state.
interface tap_ctrl_if;
   logic tms_i;
   logic reset_o;
   logic select_o;
   logic ir_shift_o;
   logic ir_clock_o;
   logic ir_upd_o;
   logic dr_shift_o;
   logic dr_clock_o;
   logic dr_upd_o;
   logic tdo_en_o;

   modport slave (
      input  tms_i,
      output reset_o, select_o,
      output ir_shift_o, ir_clock_o, ir_upd_o,
      output dr_shift_o, dr_clock_o, dr_upd_o,
      output tdo_en_o
   );

   modport master (
      output tms_i,
      input  reset_o, select_o,
      input  ir_shift_o, ir_clock_o, ir_upd_o,
      input  dr_shift_o, dr_clock_o, dr_upd_o,
      input  tdo_en_o
   );
endinterface

// File: rtl/tap_ctrl_out_dec.sv
// tapc_out_dec: pure combinational decode of a TAP state into chain controls.
// The top feeds it the next state so the registered result lines up with the
// state register.
module tapc_out_dec
   import tap_ctrl_pkg::*;
(
   input  tapc_state_t i_state,
   output tapc_out_t   o_out
);

   // Each control is a plain membership test on the state.
   always_comb begin
      o_out          = '0;
      o_out.reset    = (i_state == TLR);
      o_out.select   = (i_state == SEL_IR) || (i_state == CAP_IR) ||
                       (i_state == SH_IR)  || (i_state == EX1_IR) ||
                       (i_state == PAUSE_IR) || (i_state == EX2_IR) ||
                       (i_state == UPD_IR);
      o_out.ir_shift = (i_state == SH_IR);
      o_out.ir_clock = (i_state == CAP_IR) || (i_state == SH_IR);
      o_out.ir_upd   = (i_state == UPD_IR);
      o_out.dr_shift = (i_state == SH_DR);
      o_out.dr_clock = (i_state == CAP_DR) || (i_state == SH_DR);
      o_out.dr_upd   = (i_state == UPD_DR);
      o_out.tdo_en   = (i_state == SH_IR) || (i_state == SH_DR);
   end

endmodule

// File: rtl/tap_ctrl.sv
// tap_ctrl: IEEE 1149.1 TAP controller. Walks the 16-state TAP graph on tms_i
// and drives IR/DR chain controls, test-logic reset and TDO enable.
// Outputs are registered from the decode of the next state, so they change
// together with the state register and never depend combinationally on tms_i.
// Build option: define TAPC_STATE_OUT_EN to add the state_o port (current state).
module tap_ctrl
   import tap_ctrl_pkg::*;
(
   input  logic        tck_i,
   input  logic        trst_i,
   tap_ctrl_if.slave   bus
`ifdef TAPC_STATE_OUT_EN
   ,
   output logic [3:0]  state_o
`endif
);

   tapc_state_t r_state;
   tapc_state_t w_next;
   tapc_out_t   r_out;
   tapc_out_t   w_dec;

   // Standard TAP transition graph; illegal encodings fall back to TLR.
   always_comb begin
      w_next = TLR;
      case (r_state)
         TLR:      w_next = bus.tms_i ? TLR      : RTI;
         RTI:      w_next = bus.tms_i ? SEL_DR   : RTI;
         SEL_DR:   w_next = bus.tms_i ? SEL_IR   : CAP_DR;
         CAP_DR:   w_next = bus.tms_i ? EX1_DR   : SH_DR;
         SH_DR:    w_next = bus.tms_i ? EX1_DR   : SH_DR;
         EX1_DR:   w_next = bus.tms_i ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: w_next = bus.tms_i ? EX2_DR   : PAUSE_DR;
         EX2_DR:   w_next = bus.tms_i ? UPD_DR   : SH_DR;
         UPD_DR:   w_next = bus.tms_i ? SEL_DR   : RTI;
         SEL_IR:   w_next = bus.tms_i ? TLR      : CAP_IR;
         CAP_IR:   w_next = bus.tms_i ? EX1_IR   : SH_IR;
         SH_IR:    w_next = bus.tms_i ? EX1_IR   : SH_IR;
         EX1_IR:   w_next = bus.tms_i ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: w_next = bus.tms_i ? EX2_IR   : PAUSE_IR;
         EX2_IR:   w_next = bus.tms_i ? UPD_IR   : SH_IR;
         UPD_IR:   w_next = bus.tms_i ? SEL_DR   : RTI;
         default:  w_next = TLR;
      endcase
   end

   tapc_out_dec u_dec (
      .i_state (w_next),
      .o_out   (w_dec)
   );

   // State and decoded outputs register together; trst_i drops every enable at once.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         r_state <= TLR;
         r_out   <= TAPC_OUT_RESET;
      end else begin
         r_state <= w_next;
         r_out   <= w_dec;
      end
   end

   assign bus.reset_o    = r_out.reset;
   assign bus.select_o   = r_out.select;
   assign bus.ir_shift_o = r_out.ir_shift;
   assign bus.ir_clock_o = r_out.ir_clock;
   assign bus.ir_upd_o   = r_out.ir_upd;
   assign bus.dr_shift_o = r_out.dr_shift;
   assign bus.dr_clock_o = r_out.dr_clock;
   assign bus.dr_upd_o   = r_out.dr_upd;
   assign bus.tdo_en_o   = r_out.tdo_en;

`ifdef TAPC_STATE_OUT_EN
   assign state_o = r_state;
`endif

endmodule

// File: tb/tb_tap_ctrl.sv
// tb_tap_ctrl: directed and random checks of tap_ctrl against a behavioural
// model of the TAP graph. Model states are abstract indices:
//   0 TLR, 1 RTI, 2..8 DR column (SEL,CAP,SH,EX1,PAUSE,EX2,UPD), 9..15 IR column.
module tb_tap_ctrl;

   logic tck;
   logic trst;
   int   n_tests;
   int   n_fail;
   int   m;
   int   dr_shift_cnt;
   logic prev_ir_upd;
   logic prev_dr_upd;

   tap_ctrl_if bus ();

`ifdef TAPC_STATE_OUT_EN
   logic [3:0] state_o;
`endif

   tap_ctrl dut (
      .tck_i  (tck),
      .trst_i (trst),
      .bus    (bus.slave)
`ifdef TAPC_STATE_OUT_EN
      ,
      .state_o (state_o)
`endif
   );

   // Clock: 10 time-unit period.
   initial begin
      tck = 1'b0;
      forever #5 tck = ~tck;
   end

   // Model: next state from the graph rules, expressed per column position.
   function automatic int model_next(int s, bit t);
      int base;
      int k;
      if (s == 0) return t ? 0 : 1;
      if (s == 1) return t ? 2 : 1;
      if (s == 2) return t ? 9 : 3;
      if (s == 9) return t ? 0 : 10;
      base = (s >= 9) ? 9 : 2;
      k    = s - base;
      case (k)
         1, 2:    return base + (t ? 3 : 2);
         3:       return base + (t ? 6 : 4);
         4:       return base + (t ? 5 : 4);
         5:       return base + (t ? 6 : 2);
         default: return t ? 2 : 1;
      endcase
   endfunction

   // Expected controls {reset,select,ir_shift,ir_clock,ir_upd,dr_shift,dr_clock,dr_upd,tdo_en}.
   function automatic logic [8:0] exp_vec(int s);
      return {1'(s == 0), 1'(s >= 9), 1'(s == 11), 1'(s == 10 || s == 11), 1'(s == 15),
              1'(s == 4), 1'(s == 3 || s == 4), 1'(s == 8), 1'(s == 4 || s == 11)};
   endfunction

   function automatic logic [3:0] exp_enc(int s);
      logic [3:0] enc [16];
      enc = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
              4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
      return enc[s];
   endfunction

   function automatic logic [8:0] obs_vec();
      return {bus.reset_o, bus.select_o, bus.ir_shift_o, bus.ir_clock_o, bus.ir_upd_o,
              bus.dr_shift_o, bus.dr_clock_o, bus.dr_upd_o, bus.tdo_en_o};
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check(tag, obs_vec(), exp_vec(m));
`ifdef TAPC_STATE_OUT_EN
      check({tag, "_state"}, {5'd0, state_o}, {5'd0, exp_enc(m)});
`endif
   endtask

   // Driver: present tms, take one rising edge, advance the model, check 1 unit later.
   task automatic step(input bit t);
      bus.tms_i = t;
      @(posedge tck);
      m = model_next(m, t);
      #1;
      check_all("step");
   endtask

   task automatic step_seq(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) step(bits[i]);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      m       = 0;
      trst    = 1'b1;
      bus.tms_i = 1'b0;

      // 1: reset state asserted with no clock edge yet.
      #1;
      check_all("reset_async");
      #2;
      trst = 1'b0;
      @(posedge tck);
      #1;
      m = model_next(m, 1'b0);
      check_all("after_release");

      // 2: back to TLR, then IR capture / shift / update.
      step_seq(16'b11111, 5);
      check("tlr_reset_o", {8'd0, bus.reset_o}, 9'd1);
      step_seq(16'b0110, 4);
      check("ir_capture", {8'd0, bus.ir_clock_o}, 9'd1);
      step_seq(16'b000, 3);
      check("ir_shift_group", {6'd0, bus.ir_shift_o, bus.tdo_en_o, bus.select_o}, 9'b111);
      step_seq(16'b11, 2);
      check("ir_update", {8'd0, bus.ir_upd_o}, 9'd1);
      step(1'b0);
      check("ir_upd_one_cycle", {8'd0, bus.ir_upd_o}, 9'd0);

      // 3: DR scan with pause and re-entry to shift through EX2_DR.
      dr_shift_cnt = 0;
      for (int i = 9; i >= 0; i--) begin
         logic [9:0] seq;
         seq = 10'b1000101011;
         step(seq[i]);
         if (bus.dr_shift_o) dr_shift_cnt++;
      end
      check("dr_shift_cycles", 9'(dr_shift_cnt), 9'd3);
      check("dr_update", {8'd0, bus.dr_upd_o}, 9'd1);
      step(1'b0);
      check("dr_upd_one_cycle", {8'd0, bus.dr_upd_o}, 9'd0);

      // 4: from each of the 16 states, five tms=1 edges reach TLR.
      for (int tgt = 0; tgt < 16; tgt++) begin
         int guard;
         guard = 0;
         while (m != tgt && guard < 400) begin
            step(1'($urandom_range(0, 1)));
            guard++;
         end
         check("reach_state", 9'(m), 9'(tgt));
         step_seq(16'b11111, 5);
         check("five_ones_tlr", {8'd0, bus.reset_o}, 9'd1);
      end

      // 5: asynchronous reset while shifting IR.
      step_seq(16'b11111, 5);
      step_seq(16'b01100, 5);
      check("in_sh_ir", {7'd0, bus.ir_shift_o, bus.tdo_en_o}, 9'b11);
      bus.tms_i = 1'b0;
      #3;
      trst = 1'b1;
      #1;
      m = 0;
      check("trst_mid_shift", {6'd0, bus.ir_shift_o, bus.tdo_en_o, bus.reset_o}, 9'b001);
      check_all("trst_mid_shift_all");
      #2;
      trst = 1'b0;
      step(1'b0);
      check("post_trst_rti", {7'd0, bus.reset_o, bus.select_o}, 9'b00);

      // 6: random tms against the model with exclusivity and pulse checks.
      prev_ir_upd = bus.ir_upd_o;
      prev_dr_upd = bus.dr_upd_o;
      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 1)));
         check("shift_excl", {8'd0, bus.ir_shift_o & bus.dr_shift_o}, 9'd0);
         check("upd_pulse", {7'd0, prev_ir_upd & bus.ir_upd_o, prev_dr_upd & bus.dr_upd_o}, 9'd0);
         prev_ir_upd = bus.ir_upd_o;
         prev_dr_upd = bus.dr_upd_o;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
